// File: rtl/cpu_debug_ctrl_if.sv
// Monitor-page bus between the CPU-side address decoder/ROM and the debug controller.
interface cpu_debug_ctrl_if;
    logic [7:0] A;
    logic       cs;
    logic       write;
    logic [7:0] Din;
    logic [7:0] rom_q;
    logic [7:0] Dout;

    modport master (output A, cs, write, Din, rom_q, input Dout);
    modport slave  (input A, cs, write, Din, rom_q, output Dout);
endinterface

// File: rtl/cpu_debug_ctrl.sv
// 6502 debug controller: NMI halt request, vector-fetch detect, monitor overlay, shadow regs, stepping.
// Optional hardware breakpoint enabled by defining CPU_DEBUG_BREAKPOINT_EN.
module cpu_debug_ctrl #(
    parameter logic [7:0]  REG_BASE   = 8'hF0,
    parameter int          NMI_PULSE  = 128,
    parameter logic [15:0] VEC_ADDR   = 16'hFFFA,
    parameter int          STEP_INSNS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cpu_debug_ctrl_if.slave        mon,
    input  logic                   b_step,
    input  logic                   b_runhalt,
    input  logic [15:0]            cpu_addr,
    input  logic                   cpu_rd,
    input  logic                   cpu_sync,
    input  logic                   cpu_valid,
    output logic [7:0]             acc,
    output logic [7:0]             x,
    output logic [7:0]             y,
    output logic [7:0]             sp,
    output logic [7:0]             sr,
    output logic [15:0]            pc,
    output logic                   nmi_n,
    output logic                   overlay,
    output logic                   stopped
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_STOPPED = 2'd1,
        S_ARMED   = 2'd2,
        S_STEP    = 2'd3
    } state_t;

    localparam int            CW       = $clog2(NMI_PULSE);
    localparam logic [CW-1:0] PULSE_M1 = CW'(NMI_PULSE - 1);
`ifdef CPU_DEBUG_BREAKPOINT_EN
    localparam logic [7:0]    WIN_LAST = 8'd11;
`else
    localparam logic [7:0]    WIN_LAST = 8'd8;
`endif

    state_t        state_q, state_d;
    logic          ovl_q, ovl_d;
    logic [7:0]    step_q, step_d;
    logic          nmi_req;
    logic          nmi_n_q;
    logic [CW-1:0] nmi_cnt_q;
    logic [7:0]    regs_q [0:6];
    logic          hit_q;
    logic [7:0]    rdata_q;
    logic [7:0]    rd_data;
    logic          bp_fire;
    logic          bp_hit;

    logic [7:0] off;
    logic       win, wr, cmd_resume, cmd_step, vec_hit, sync_ev;
    assign off        = mon.A - REG_BASE;
    assign win        = (off <= WIN_LAST);
    assign wr         = mon.cs & mon.write;
    assign cmd_resume = wr & (off == 8'd8) & mon.Din[0];
    assign cmd_step   = wr & (off == 8'd8) & mon.Din[1];
    assign vec_hit    = cpu_valid & cpu_rd & (cpu_addr == VEC_ADDR);
    assign sync_ev    = cpu_valid & cpu_sync;

`ifdef CPU_DEBUG_BREAKPOINT_EN
    logic [15:0] bp_q;
    logic        bpen_q, bp_hit_q;
    assign bp_fire = bpen_q & sync_ev & (cpu_addr == bp_q);
    assign bp_hit  = bp_hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_q     <= '0;
            bpen_q   <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            if (wr && off == 8'd9)  bp_q[7:0]  <= mon.Din;
            if (wr && off == 8'd10) bp_q[15:8] <= mon.Din;
            if (wr && off == 8'd11) begin
                bpen_q   <= mon.Din[0];
                bp_hit_q <= 1'b0;
            end
            // a new hit in the same cycle as a bpctl write stays visible
            if (state_q == S_RUN && bp_fire) bp_hit_q <= 1'b1;
        end
    end
`else
    assign bp_fire = 1'b0;
    assign bp_hit  = 1'b0;
`endif

    always_comb begin
        rd_data = 8'h00;
        case (off)
            8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6: rd_data = regs_q[off[2:0]];
            8'd7: rd_data = {state_q == S_STOPPED, state_q == S_STEP, bp_hit, 3'b000, state_q};
`ifdef CPU_DEBUG_BREAKPOINT_EN
            8'd9:  rd_data = bp_q[7:0];
            8'd10: rd_data = bp_q[15:8];
            8'd11: rd_data = {7'd0, bpen_q};
`endif
            default: rd_data = 8'h00;
        endcase
    end

    // hit_q resets high with zero data so Dout reads 0 while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) regs_q[i] <= 8'h00;
            hit_q   <= 1'b1;
            rdata_q <= 8'h00;
        end else begin
            hit_q   <= mon.cs & ~mon.write & win;
            rdata_q <= rd_data;
            if (wr && off < 8'd7) regs_q[off[2:0]] <= mon.Din;
        end
    end

    always_comb begin
        state_d = state_q;
        ovl_d   = ovl_q;
        step_d  = step_q;
        nmi_req = 1'b0;
        case (state_q)
            S_RUN: begin
                if (bp_fire | b_runhalt | b_step) begin
                    nmi_req = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (vec_hit) begin
                    state_d = S_STOPPED;
                    ovl_d   = 1'b1;
                end
            end
            S_STOPPED: begin
                if (cmd_resume)     state_d = S_RUN;
                else if (cmd_step)  state_d = S_STEP;
                else if (b_runhalt) state_d = S_RUN;
                else if (b_step)    state_d = S_STEP;
                if (state_d != S_STOPPED) begin
                    ovl_d  = 1'b0;
                    step_d = 8'd0;
                end
            end
            S_STEP: begin
                // the fetch after STEP_INSNS completed instructions re-halts
                if (sync_ev) begin
                    if (step_q == 8'(STEP_INSNS)) begin
                        nmi_req = 1'b1;
                        state_d = S_ARMED;
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            ovl_q     <= 1'b0;
            step_q    <= 8'd0;
            nmi_n_q   <= 1'b1;
            nmi_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ovl_q   <= ovl_d;
            step_q  <= step_d;
            if (!nmi_n_q) begin
                if (nmi_cnt_q == '0) nmi_n_q   <= 1'b1;
                else                 nmi_cnt_q <= nmi_cnt_q - 1'b1;
            end else if (nmi_req) begin
                nmi_n_q   <= 1'b0;
                nmi_cnt_q <= PULSE_M1;
            end
        end
    end

    assign mon.Dout = hit_q ? rdata_q : mon.rom_q;
    assign acc      = regs_q[0];
    assign x        = regs_q[1];
    assign y        = regs_q[2];
    assign sp       = regs_q[3];
    assign pc       = {regs_q[5], regs_q[4]};
    assign sr       = regs_q[6];
    assign nmi_n    = nmi_n_q;
    assign overlay  = ovl_q;
    assign stopped  = (state_q == S_STOPPED);
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: register-window vector table, halt/step/reset sequences, random run vs model.
module tb_cpu_debug_ctrl;
    localparam logic [7:0]  REG_BASE   = 8'hF0;
    localparam int          NMI_PULSE  = 128;
    localparam logic [15:0] VEC_ADDR   = 16'hFFFA;
    localparam int          STEP_INSNS = 1;
`ifdef CPU_DEBUG_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif
    localparam int M_RUN = 0, M_STOP = 1, M_ARMED = 2, M_STEP = 3;

    logic clk = 1'b0, rst_n = 1'b1;
    logic b_step, b_runhalt, cpu_rd, cpu_sync, cpu_valid;
    logic [15:0] cpu_addr, pc;
    logic [7:0] acc, x, y, sp, sr;
    logic nmi_n, overlay, stopped;
    int n_vec = 0, n_bad = 0;

    cpu_debug_ctrl_if mon();

    cpu_debug_ctrl #(.REG_BASE(REG_BASE), .NMI_PULSE(NMI_PULSE), .VEC_ADDR(VEC_ADDR),
                     .STEP_INSNS(STEP_INSNS)) dut (
        .clk(clk), .rst_n(rst_n), .mon(mon), .b_step(b_step), .b_runhalt(b_runhalt),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_sync(cpu_sync), .cpu_valid(cpu_valid),
        .acc(acc), .x(x), .y(y), .sp(sp), .sr(sr), .pc(pc),
        .nmi_n(nmi_n), .overlay(overlay), .stopped(stopped));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mon.cs = 0; mon.write = 0; mon.A = 8'h00; mon.Din = 8'h00;
        b_step = 0; b_runhalt = 0;
        cpu_valid = 0; cpu_rd = 0; cpu_sync = 0; cpu_addr = 16'h0000;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        mon.cs = 1; mon.write = 1; mon.A = a; mon.Din = d;
        tick();
        idle();
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        mon.cs = 1; mon.write = 0; mon.A = a;
        tick();
        chk(name, mon.Dout, exp);
        idle();
    endtask

    // counts ticks until nmi_n returns high, bounded
    task automatic wait_nmi_end(output int n);
        n = 0;
        while (nmi_n === 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk("nmi_end_bound", 32'(n < 400), 32'd1);
    endtask

    task automatic vec_fetch();
        cpu_valid = 1; cpu_rd = 1; cpu_addr = VEC_ADDR;
        tick();
        idle();
    endtask

    task automatic sync_at(input logic [15:0] a);
        cpu_valid = 1; cpu_sync = 1; cpu_addr = a;
        tick();
        idle();
    endtask

    task automatic halt_cpu();
        int n;
        b_runhalt = 1;
        tick();
        idle();
        wait_nmi_end(n);
        vec_fetch();
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_regs [0:6];
    int          m_mode, m_nmi_left, m_steps;
    bit          m_ovl, m_hit, m_bpen, m_bphit;
    logic [7:0]  m_rdata;
    logic [15:0] m_bp;

    function automatic logic [7:0] model_read(input logic [7:0] o);
        logic [7:0] v;
        v = 8'h00;
        if (o < 8'd7) v = m_regs[o];
        else if (o == 8'd7) v = {m_mode == M_STOP, m_mode == M_STEP, m_bphit, 3'b000, 2'(m_mode)};
        else if (BP_EN && o == 8'd9)  v = m_bp[7:0];
        else if (BP_EN && o == 8'd10) v = m_bp[15:8];
        else if (BP_EN && o == 8'd11) v = {7'd0, m_bpen};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_regs[i] = 8'h00;
        m_mode = M_RUN; m_nmi_left = 0; m_steps = 0; m_ovl = 0;
        m_hit = 1; m_rdata = 8'h00; m_bp = 16'h0000; m_bpen = 0; m_bphit = 0;
    endtask

    task automatic model_step();
        logic [7:0] o;
        bit ctl, res, stp, req, fire, sev, wr_en;
        o     = mon.A - REG_BASE;
        wr_en = mon.cs && mon.write;
        sev   = cpu_valid && cpu_sync;
        m_hit   = mon.cs && !mon.write && (o <= (BP_EN ? 8'd11 : 8'd8));
        m_rdata = model_read(o);
        ctl  = wr_en && o == 8'd8;
        res  = ctl && mon.Din[0];
        stp  = ctl && mon.Din[1];
        fire = BP_EN && m_bpen && sev && cpu_addr == m_bp && m_mode == M_RUN;
        req  = 0;
        case (m_mode)
            M_RUN:   if (fire || b_runhalt || b_step) begin req = 1; m_mode = M_ARMED; end
            M_ARMED: if (cpu_valid && cpu_rd && cpu_addr == VEC_ADDR) begin m_mode = M_STOP; m_ovl = 1; end
            M_STOP: begin
                if (res || (!stp && b_runhalt)) m_mode = M_RUN;
                else if (stp || b_step) m_mode = M_STEP;
                if (m_mode != M_STOP) begin m_ovl = 0; m_steps = 0; end
            end
            default: if (sev) begin
                m_steps++;
                if (m_steps == STEP_INSNS + 1) begin req = 1; m_mode = M_ARMED; end
            end
        endcase
        if (wr_en && o < 8'd7) m_regs[o] = mon.Din;
        if (BP_EN && wr_en && o == 8'd9)  m_bp[7:0]  = mon.Din;
        if (BP_EN && wr_en && o == 8'd10) m_bp[15:8] = mon.Din;
        if (BP_EN && wr_en && o == 8'd11) begin m_bpen = mon.Din[0]; m_bphit = 0; end
        if (fire) m_bphit = 1;
        if (m_nmi_left > 0) m_nmi_left--;
        else if (req) m_nmi_left = NMI_PULSE;
    endtask

    typedef struct {
        logic       cs, we;
        logic [7:0] a, din, rom, exp;
    } vec_t;
    vec_t tbl [19];

    initial begin
        int n;
        tbl[0]  = '{1'b1, 1'b1, 8'hF1, 8'h5A, 8'h33, 8'h33};
        tbl[1]  = '{1'b1, 1'b0, 8'hF1, 8'h00, 8'h44, 8'h5A};
        tbl[2]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h77, 8'h77};
        tbl[3]  = '{1'b1, 1'b1, 8'hF0, 8'h11, 8'h01, 8'h01};
        tbl[4]  = '{1'b1, 1'b1, 8'hF2, 8'h22, 8'h02, 8'h02};
        tbl[5]  = '{1'b1, 1'b1, 8'hF3, 8'h33, 8'h03, 8'h03};
        tbl[6]  = '{1'b1, 1'b1, 8'hF4, 8'h44, 8'h04, 8'h04};
        tbl[7]  = '{1'b1, 1'b1, 8'hF5, 8'h55, 8'h05, 8'h05};
        tbl[8]  = '{1'b1, 1'b1, 8'hF6, 8'h66, 8'h06, 8'h06};
        tbl[9]  = '{1'b1, 1'b0, 8'hF0, 8'h00, 8'h00, 8'h11};
        tbl[10] = '{1'b1, 1'b0, 8'hF2, 8'h00, 8'h00, 8'h22};
        tbl[11] = '{1'b1, 1'b0, 8'hF3, 8'h00, 8'h00, 8'h33};
        tbl[12] = '{1'b1, 1'b0, 8'hF4, 8'h00, 8'h00, 8'h44};
        tbl[13] = '{1'b1, 1'b0, 8'hF5, 8'h00, 8'h00, 8'h55};
        tbl[14] = '{1'b1, 1'b0, 8'hF6, 8'h00, 8'h00, 8'h66};
        tbl[15] = '{1'b1, 1'b0, 8'hF7, 8'h00, 8'h99, 8'h00};
        tbl[16] = '{1'b1, 1'b0, 8'hF8, 8'h00, 8'h98, 8'h00};
        tbl[17] = '{1'b1, 1'b0, 8'hEF, 8'h00, 8'h97, 8'h97};
        tbl[18] = '{1'b0, 1'b0, 8'hF1, 8'h00, 8'h96, 8'h96};

        idle();
        mon.rom_q = 8'hC3;
        #2 rst_n = 0;
        tick(); tick();
        chk("rst_dout", mon.Dout, 8'h00);
        chk("rst_nmi", nmi_n, 1'b1);
        chk("rst_ovl", overlay, 1'b0);
        chk("rst_stopped", stopped, 1'b0);
        chk("rst_regs", {acc, x, y, sp, sr, pc}, 56'h0);
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 19; i++) begin
            mon.cs = tbl[i].cs; mon.write = tbl[i].we; mon.A = tbl[i].a;
            mon.Din = tbl[i].din; mon.rom_q = tbl[i].rom;
            tick();
            chk($sformatf("tbl%0d", i), mon.Dout, tbl[i].exp);
        end
        idle();
        chk("shadow", {acc, x, y, sp, sr, pc}, {8'h11, 8'h5A, 8'h22, 8'h33, 8'h66, 16'h5544});
        mon.rom_q = 8'hA5;
        rd("off9", 8'hF9, BP_EN ? 8'h00 : 8'hA5);

        // halt request: pulse length, buttons ignored while armed
        b_runhalt = 1;
        tick();
        b_runhalt = 0;
        chk("nmi_low_next", nmi_n, 1'b0);
        n = 0;
        while (nmi_n === 1'b0 && n < 400) begin
            b_step = (n == 10);
            tick();
            n++;
        end
        b_step = 0;
        chk("nmi_len", n, NMI_PULSE);
        rd("armed_status", 8'hF7, 8'h02);
        chk("armed_nmi_idle", nmi_n, 1'b1);
        vec_fetch();
        chk("halt_stopped", stopped, 1'b1);
        chk("halt_ovl", overlay, 1'b1);
        rd("stop_status", 8'hF7, 8'h81);
        chk("stop_ovl_hold", overlay, 1'b1);

        // single step: first sync runs, second sync re-halts
        wr(8'hF8, 8'h02);
        chk("step_ovl", overlay, 1'b0);
        chk("step_stopped", stopped, 1'b0);
        rd("step_status", 8'hF7, 8'h43);
        sync_at(16'h1234);
        chk("step_sync1_nmi", nmi_n, 1'b1);
        rd("step_sync1_status", 8'hF7, 8'h43);
        sync_at(16'h1236);
        chk("step_sync2_nmi", nmi_n, 1'b0);
        rd("step_rearm_status", 8'hF7, 8'h02);
        wait_nmi_end(n);
        vec_fetch();
        chk("step_restop", stopped, 1'b1);

        // resume+step write with concurrent b_step: resume wins, no NMI
        mon.cs = 1; mon.write = 1; mon.A = 8'hF8; mon.Din = 8'h03; b_step = 1;
        tick();
        idle();
        chk("res_stopped", stopped, 1'b0);
        chk("res_ovl", overlay, 1'b0);
        tick(); tick();
        chk("res_nmi", nmi_n, 1'b1);
        rd("res_status", 8'hF7, 8'h00);

        // both buttons while stopped -> run
        halt_cpu();
        b_runhalt = 1; b_step = 1;
        tick();
        idle();
        rd("both_btn_status", 8'hF7, 8'h00);
        chk("both_btn_nmi", nmi_n, 1'b1);

        // reset in the middle of a pulse
        b_runhalt = 1;
        tick();
        idle();
        repeat (39) tick();
        chk("mid_nmi_low", nmi_n, 1'b0);
        rst_n = 0;
        #1;
        chk("mid_rst_nmi", nmi_n, 1'b1);
        chk("mid_rst_ovl", overlay, 1'b0);
        chk("mid_rst_regs", {acc, x, pc}, 32'h0);
        @(negedge clk) rst_n = 1;
        rd("mid_rst_status", 8'hF7, 8'h00);
        rd("mid_rst_x", 8'hF1, 8'h00);

        // breakpoint
        wr(8'hF9, 8'h12);
        wr(8'hFA, 8'hC0);
        wr(8'hFB, 8'h01);
        sync_at(16'hC012);
        chk("bp_nmi", nmi_n, BP_EN ? 1'b0 : 1'b1);
        rd("bp_status", 8'hF7, BP_EN ? 8'h22 : 8'h00);

        // randomized run against the model
        rst_n = 0;
        tick();
        @(negedge clk) rst_n = 1;
        model_reset();
        for (int c = 0; c < 5000; c++) begin
            mon.cs    = ($urandom_range(0, 3) == 0);
            mon.write = $urandom_range(0, 1);
            mon.A     = ($urandom_range(0, 4) == 0) ? 8'($urandom) : REG_BASE + 8'($urandom_range(0, 12));
            mon.Din   = 8'($urandom);
            mon.rom_q = 8'($urandom);
            b_step    = ($urandom_range(0, 49) == 0);
            b_runhalt = ($urandom_range(0, 49) == 0);
            cpu_valid = $urandom_range(0, 1);
            cpu_rd    = $urandom_range(0, 1);
            cpu_sync  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       cpu_addr = VEC_ADDR;
                1:       cpu_addr = 16'hC012;
                default: cpu_addr = 16'($urandom);
            endcase
            model_step();
            tick();
            chk("r_dout", mon.Dout, m_hit ? m_rdata : mon.rom_q);
            chk("r_nmi", nmi_n, m_nmi_left == 0);
            chk("r_ovl", overlay, m_ovl);
            chk("r_stopped", stopped, m_mode == M_STOP);
            chk("r_regs", {acc, x, y, sp, sr},
                {m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[6]});
            chk("r_pc", pc, {m_regs[5], m_regs[4]});
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
